filter_ctrl_fsm: RTL

Parametrised second-generation filtration controller. Drives fill pump A and drain pump B from tank-level sensors and the Pico criticality word. Adds a programmable criticality threshold, per-state watchdog timeouts with a latched FAULT state, registered PWM outputs, and an optional soft-start ramp. Sits between the status receiver and the two PWM generators.

---
 rtl/filter_pkg.sv | 36 +++
 rtl/filter_ctrl_fsm_if.sv | 26 ++
 rtl/pwm_ramp.sv | 60 ++++++
 rtl/filter_ctrl_fsm.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/filter_pkg.sv
// Shared types and defaults for the filtration controller.
// The soft-start ramp is enabled by defining FILTER_CTRL_RAMP_EN.
package filter_pkg;

    localparam int unsigned STATUS_W_DEF = 4;
    localparam int unsigned PWM_W_DEF    = 8;
    localparam int unsigned PWM_MAX_DEF  = 230;
    localparam int unsigned PWM_MIN_DEF  = 77;

    typedef logic [PWM_W_DEF-1:0] duty_t;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_FILLING      = 3'd1,
        ST_DRAINING_MIN = 3'd2,
        ST_DRAINING_MAX = 3'd3,
        ST_STOPPING     = 3'd4,
        ST_FAULT        = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        FC_NONE  = 2'd0,
        FC_FILL  = 2'd1,
        FC_DRAIN = 2'd2,
        FC_STOP  = 2'd3
    } fault_code_t;

    // Largest of three cycle counts; sizes the shared dwell timer.
    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/filter_ctrl_fsm_if.sv
// Sensor/status inputs and pump/status outputs of the filtration controller.
interface filter_ctrl_fsm_if #(
    parameter int unsigned STATUS_W = 4,
    parameter int unsigned PWM_W    = 8
);
    logic [STATUS_W-1:0] status_data;
    logic                level_a_full;
    logic                level_b_empty;
    logic                fault_clr;
    logic [PWM_W-1:0]    pwm_duty_a;
    logic [PWM_W-1:0]    pwm_duty_b;
    logic                is_critical;
    logic [2:0]          state_o;
    logic                fault;
    logic [1:0]          fault_code;

    modport master (
        output status_data, level_a_full, level_b_empty, fault_clr,
        input  pwm_duty_a, pwm_duty_b, is_critical, state_o, fault, fault_code
    );

    modport slave (
        input  status_data, level_a_full, level_b_empty, fault_clr,
        output pwm_duty_a, pwm_duty_b, is_critical, state_o, fault, fault_code
    );
endinterface

// File: rtl/pwm_ramp.sv
// Registered pump duty; with FILTER_CTRL_RAMP_EN it slews toward the target,
// otherwise it loads the target directly.
module pwm_ramp #(
    parameter int unsigned PWM_W = 8
`ifdef FILTER_CTRL_RAMP_EN
  , parameter int unsigned RAMP_STEP = 8,
    parameter int unsigned RAMP_DIV  = 50_000
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PWM_W-1:0] target,
    input  logic             force_zero,
    output logic [PWM_W-1:0] duty
);

`ifdef FILTER_CTRL_RAMP_EN
    localparam int unsigned DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [PWM_W:0]   up_sum;
    logic [PWM_W:0]   target_x;
    logic [PWM_W:0]   duty_x;

    assign tick     = (div_cnt == DIV_W'(RAMP_DIV - 1));
    assign target_x = {1'b0, target};
    assign duty_x   = {1'b0, duty};
    assign up_sum   = duty_x + (PWM_W+1)'(RAMP_STEP);

    // Free-running tick divider; each tick moves duty one step, clamped at target.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            duty    <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            if (force_zero || (target == '0)) begin
                duty <= '0;
            end else if (tick) begin
                if (duty < target) begin
                    duty <= (up_sum >= target_x) ? target : PWM_W'(up_sum);
                end else if (duty > target) begin
                    duty <= ((duty_x - target_x) <= (PWM_W+1)'(RAMP_STEP))
                            ? target : duty - PWM_W'(RAMP_STEP);
                end
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            duty <= '0;
        end else begin
            duty <= force_zero ? '0 : target;
        end
    end
`endif

endmodule

// File: rtl/filter_ctrl_fsm.sv
// Fill/drain pump controller with criticality threshold, dwell watchdogs and
// latched FAULT. Optional soft-start ramp via FILTER_CTRL_RAMP_EN.
module filter_ctrl_fsm
    import filter_pkg::*;
#(
    parameter int unsigned STATUS_W             = STATUS_W_DEF,
    parameter int unsigned PWM_W                = PWM_W_DEF,
    parameter int unsigned PWM_MAX              = PWM_MAX_DEF,
    parameter int unsigned PWM_MIN              = PWM_MIN_DEF,
    parameter int unsigned CRIT_THRESHOLD       = 1,
    parameter int unsigned DRAIN_MIN_CYCLES     = 250_000_000,
    parameter int unsigned FILL_TIMEOUT_CYCLES  = 1_500_000_000,
    parameter int unsigned DRAIN_TIMEOUT_CYCLES = 1_500_000_000
`ifdef FILTER_CTRL_RAMP_EN
  , parameter int unsigned RAMP_STEP            = 8,
    parameter int unsigned RAMP_DIV             = 50_000
`endif
) (
    input logic               clk,
    input logic               reset,
    filter_ctrl_fsm_if.slave  bus
);

    localparam int unsigned TIMER_W =
        $clog2(max3(DRAIN_MIN_CYCLES, FILL_TIMEOUT_CYCLES, DRAIN_TIMEOUT_CYCLES)) + 1;

    state_t             state, next_state;
    fault_code_t        fault_code_q, next_code;
    logic               fault_q;
    logic [TIMER_W-1:0] timer;
    logic [PWM_W-1:0]   target_a, target_b, b_drive;
    logic               crit, force_zero;

    assign crit       = (bus.status_data >= STATUS_W'(CRIT_THRESHOLD));
    assign b_drive    = bus.level_b_empty ? '0 : PWM_W'(PWM_MAX);
    assign force_zero = (next_state == ST_FAULT);

    // State, dwell timer and fault latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            timer        <= '0;
            fault_code_q <= FC_NONE;
            fault_q      <= 1'b0;
        end else begin
            state        <= next_state;
            fault_code_q <= next_code;
            fault_q      <= (next_state == ST_FAULT);
            if (next_state != state) begin
                timer <= '0;
            end else if (timer != '1) begin
                timer <= timer + TIMER_W'(1);
            end
        end
    end

    // Priority-ordered transitions and per-state duty targets.
    always_comb begin
        next_state = state;
        next_code  = fault_code_q;
        target_a   = '0;
        target_b   = '0;
        case (state)
            ST_IDLE: begin
                if (crit) next_state = ST_FILLING;
            end
            ST_FILLING: begin
                target_a = PWM_W'(PWM_MAX);
                target_b = b_drive;
                if (!crit) begin
                    next_state = ST_STOPPING;
                end else if (timer >= TIMER_W'(FILL_TIMEOUT_CYCLES)) begin
                    next_state = ST_FAULT;
                    next_code  = FC_FILL;
                end else if (bus.level_a_full) begin
                    next_state = ST_DRAINING_MIN;
                end
            end
            ST_DRAINING_MIN: begin
                target_b = PWM_W'(PWM_MIN);
                if (!crit)                                        next_state = ST_STOPPING;
                else if (bus.level_b_empty)                       next_state = ST_FILLING;
                else if (timer >= TIMER_W'(DRAIN_MIN_CYCLES))     next_state = ST_DRAINING_MAX;
            end
            ST_DRAINING_MAX: begin
                target_b = PWM_W'(PWM_MAX);
                if (!crit) begin
                    next_state = ST_STOPPING;
                end else if (bus.level_b_empty) begin
                    next_state = ST_FILLING;
                end else if (timer >= TIMER_W'(DRAIN_TIMEOUT_CYCLES)) begin
                    next_state = ST_FAULT;
                    next_code  = FC_DRAIN;
                end
            end
            ST_STOPPING: begin
                target_b = b_drive;
                if (bus.level_b_empty) begin
                    next_state = ST_IDLE;
                end else if (timer >= TIMER_W'(DRAIN_TIMEOUT_CYCLES)) begin
                    next_state = ST_FAULT;
                    next_code  = FC_STOP;
                end
            end
            ST_FAULT: begin
                if (bus.fault_clr) begin
                    next_state = ST_IDLE;
                    next_code  = FC_NONE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    pwm_ramp #(
        .PWM_W     (PWM_W)
`ifdef FILTER_CTRL_RAMP_EN
      , .RAMP_STEP (RAMP_STEP),
        .RAMP_DIV  (RAMP_DIV)
`endif
    ) u_ramp_a (
        .clk        (clk),
        .reset      (reset),
        .target     (target_a),
        .force_zero (force_zero),
        .duty       (bus.pwm_duty_a)
    );

    pwm_ramp #(
        .PWM_W     (PWM_W)
`ifdef FILTER_CTRL_RAMP_EN
      , .RAMP_STEP (RAMP_STEP),
        .RAMP_DIV  (RAMP_DIV)
`endif
    ) u_ramp_b (
        .clk        (clk),
        .reset      (reset),
        .target     (target_b),
        .force_zero (force_zero),
        .duty       (bus.pwm_duty_b)
    );

    assign bus.is_critical = crit;
    assign bus.state_o     = state;
    assign bus.fault       = fault_q;
    assign bus.fault_code  = fault_code_q;

endmodule
